// File: rtl/pe_drain_pkg.sv
// pe_drain_pkg: shared types and helpers for the PE-array drain controller.
//   drain_state_e : controller FSM states
//   num_pairs()   : number of column pairs (P) for a given column count
//   pe_idx()      : flat PE index from (row, column)
package pe_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    function automatic int unsigned num_pairs(input int unsigned num_pe_col);
        return num_pe_col / 2;
    endfunction

    function automatic int unsigned pe_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned num_pe_col);
        return c + r * num_pe_col;
    endfunction

endpackage

// File: rtl/pe_array_drain_ctrl_if.sv
// pe_array_drain_ctrl_if: valid/ready result stream from the drain controller to the
// output buffer.
//   out_valid : beat valid (master -> slave)
//   out_ready : output buffer ready (slave -> master)
//   out_data  : per row {odd, even}, row 0 in the LSBs (master -> slave)
interface pe_array_drain_ctrl_if #(
    parameter int unsigned NUM_PE_ROW   = 1,
    parameter int unsigned OUTPUT_WIDTH = 24
);
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NUM_PE_ROW*2*OUTPUT_WIDTH-1:0]  out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/pe_drain_token_pipe.sv
// pe_drain_token_pipe: P-deep token shift register tracking in-flight chain words.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : shift enable (low freezes every token)
//   ins_vld    : a new word is issued this cycle
//   ins_pos    : pair index of the issue; the token enters at that stage
//   tok        : token bits, tok[P-1] marks a word at the rightmost column
module pe_drain_token_pipe #(
    parameter int unsigned P  = 1,
    parameter int unsigned KW = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          ins_vld,
    input  logic [KW-1:0] ins_pos,
    output logic [P-1:0]  tok
);

    logic [P-1:0] tok_q, tok_d;

    always_comb begin
        tok_d = tok_q;
        if (en) begin
            tok_d[0] = ins_vld && (ins_pos == '0);
            for (int j = 1; j < P; j++) begin
                // The issue slot never collides with a shifting token.
                tok_d[j] = tok_q[j-1] | (ins_vld && (ins_pos == KW'(j)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tok_q <= '0;
        end else begin
            tok_q <= tok_d;
        end
    end

    assign tok = tok_q;

endmodule

// File: rtl/pe_array_drain_ctrl.sv
// pe_array_drain_ctrl: sequences readout of the PE accumulator FIFOs through the two-lane
// out_to_right chain and presents rightmost-column results on a valid/ready stream.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start, n_entries      : begin a drain of n_entries words per ACCFIFO
//   busy, done            : drain in progress / 1-cycle completion pulse
//   underflow_err         : sticky; an issued PE had an empty ACCFIFO
//   pe_ctrl_*             : per-PE pop, output mux select and output register enable
//   pe_ctrl_ACCFIFO_empty : per-PE FIFO empty flags
//   out_fr_rightest_PE_*  : chain outputs at the two rightmost columns
//   out_if                : result stream (master)
//   stall_cycles          : only with PE_DRAIN_STALL_CNT_EN defined; cycles busy with a
//                           beat held by backpressure, saturating
module pe_array_drain_ctrl
    import pe_drain_pkg::*;
#(
    parameter int unsigned NUM_PE_ROW   = 1,
    parameter int unsigned NUM_PE_COL   = 2,
    parameter int unsigned TOTAL_NUM_PE = NUM_PE_ROW * NUM_PE_COL,
    parameter int unsigned OUTPUT_WIDTH = 24,
    parameter int unsigned CNT_W        = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [CNT_W-1:0]                   n_entries,
    output logic                               busy,
    output logic                               done,
    output logic                               underflow_err,
    output logic [TOTAL_NUM_PE-1:0]            pe_ctrl_ACCFIFO_read_to_outbuffer,
    output logic [TOTAL_NUM_PE-1:0]            pe_ctrl_out_mux_sel_PE,
    output logic [TOTAL_NUM_PE-1:0]            pe_ctrl_out_to_right_pe_en,
    input  logic [TOTAL_NUM_PE-1:0]            pe_ctrl_ACCFIFO_empty,
    input  logic [NUM_PE_ROW*OUTPUT_WIDTH-1:0] out_fr_rightest_PE_even_col,
    input  logic [NUM_PE_ROW*OUTPUT_WIDTH-1:0] out_fr_rightest_PE_odd_col,
`ifdef PE_DRAIN_STALL_CNT_EN
    output logic [15:0]                        stall_cycles,
`endif
    pe_array_drain_ctrl_if.master              out_if
);

    localparam int unsigned P  = num_pairs(NUM_PE_COL);
    localparam int unsigned KW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned W  = OUTPUT_WIDTH;

    drain_state_e      state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic              done_q, done_d;
    logic              uflow_q, uflow_d;

    logic                    en;
    logic                    issue;
    logic                    start_acc;
    logic [TOTAL_NUM_PE-1:0] issue_mask;
    logic [P-1:0]            tok;

    // Any held beat freezes the whole chain so nothing is overwritten.
    assign out_if.out_valid = tok[P-1];
    assign en        = !(out_if.out_valid && !out_if.out_ready);
    assign issue     = (state_q == DRAIN) && en;
    assign start_acc = (state_q == IDLE) && start;

    always_comb begin
        issue_mask = '0;
        for (int r = 0; r < NUM_PE_ROW; r++) begin
            for (int c = 0; c < NUM_PE_COL; c++) begin
                issue_mask[pe_idx(r, c, NUM_PE_COL)] = issue && (k_q == KW'(c / 2));
            end
        end
    end

    assign pe_ctrl_ACCFIFO_read_to_outbuffer = issue_mask;
    assign pe_ctrl_out_mux_sel_PE            = issue_mask;
    // The chain keeps shifting through FLUSH so late words reach the right edge.
    assign pe_ctrl_out_to_right_pe_en        = {TOTAL_NUM_PE{en && (state_q != IDLE)}};

    always_comb begin
        out_if.out_data = '0;
        for (int r = 0; r < NUM_PE_ROW; r++) begin
            out_if.out_data[r*2*W +: W]     = out_fr_rightest_PE_even_col[r*W +: W];
            out_if.out_data[r*2*W + W +: W] = out_fr_rightest_PE_odd_col[r*W +: W];
        end
    end

    pe_drain_token_pipe #(
        .P  (P),
        .KW (KW)
    ) u_token_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .ins_vld (issue),
        .ins_pos (k_q),
        .tok     (tok)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        done_d  = 1'b0;
        uflow_d = uflow_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n_entries;
                    k_d     = KW'(P - 1);
                    cnt_d   = '0;
                    uflow_d = 1'b0;
                    state_d = (n_entries == '0) ? FLUSH : DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (|(issue_mask & pe_ctrl_ACCFIFO_empty)) begin
                        uflow_d = 1'b1;
                    end
                    if (cnt_q == n_q - 1'b1) begin
                        if (k_q == '0) begin
                            state_d = FLUSH;
                        end else begin
                            k_d   = k_q - 1'b1;
                            cnt_d = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                if (tok == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            done_q  <= done_d;
            uflow_q <= uflow_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign underflow_err = uflow_q;

`ifdef PE_DRAIN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (busy && out_if.out_valid && !out_if.out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_pe_array_drain_ctrl.sv
// Testbench for pe_array_drain_ctrl with 2 rows x 4 columns (two column pairs). A
// behavioural PE array (per-PE FIFO queues plus the two-lane out_to_right registers)
// is driven by the DUT controls; expected beats come from the FIFO contents in
// pair-descending, FIFO order.
module tb_pe_array_drain_ctrl;

    localparam int ROW = 2;
    localparam int COL = 4;
    localparam int TOT = ROW * COL;
    localparam int W   = 24;
    localparam int CW  = 6;
    localparam int P   = COL / 2;
    localparam int DW  = 2 * ROW * W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   n_entries = '0;
    logic            busy, done, underflow_err;
    logic [TOT-1:0]  rd, sel, oten, pe_empty;
    logic [ROW*W-1:0] even_col, odd_col;
`ifdef PE_DRAIN_STALL_CNT_EN
    logic [15:0]     stall_cycles;
`endif

    pe_array_drain_ctrl_if #(.NUM_PE_ROW(ROW), .OUTPUT_WIDTH(W)) oif ();

    pe_array_drain_ctrl #(
        .NUM_PE_ROW   (ROW),
        .NUM_PE_COL   (COL),
        .TOTAL_NUM_PE (TOT),
        .OUTPUT_WIDTH (W),
        .CNT_W        (CW)
    ) dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .start                             (start),
        .n_entries                         (n_entries),
        .busy                              (busy),
        .done                              (done),
        .underflow_err                     (underflow_err),
        .pe_ctrl_ACCFIFO_read_to_outbuffer (rd),
        .pe_ctrl_out_mux_sel_PE            (sel),
        .pe_ctrl_out_to_right_pe_en        (oten),
        .pe_ctrl_ACCFIFO_empty             (pe_empty),
        .out_fr_rightest_PE_even_col       (even_col),
        .out_fr_rightest_PE_odd_col        (odd_col),
`ifdef PE_DRAIN_STALL_CNT_EN
        .stall_cycles                      (stall_cycles),
`endif
        .out_if                            (oif.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural PE array ----------------
    logic [W-1:0]   fifo [TOT][$];
    logic [W-1:0]   chain [TOT];
    logic [TOT-1:0] fifo_empty = '1;
    logic [TOT-1:0] fmask = '0;
    logic [DW-1:0]  exp_q [$];

    assign pe_empty = fifo_empty | fmask;

    for (genvar r = 0; r < ROW; r++) begin : g_edge
        assign even_col[r*W +: W] = chain[r*COL + COL - 2];
        assign odd_col[r*W +: W]  = chain[r*COL + COL - 1];
    end

    always @(posedge clk) begin
        logic [W-1:0] head;
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                int pe;
                pe = c + r * COL;
                if (!rst_n) begin
                    chain[pe] <= '0;
                end else begin
                    head = (fifo[pe].size() > 0) ? fifo[pe][0] : '0;
                    if (oten[pe]) begin
                        chain[pe] <= sel[pe] ? head : ((c >= 2) ? chain[pe-2] : '0);
                    end
                    if (rd[pe] && fifo[pe].size() > 0) begin
                        void'(fifo[pe].pop_front());
                    end
                end
                fifo_empty[pe] <= (fifo[pe].size() == 0);
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_errors = 0;
    int n_checks = 0;

    task automatic chk_eq(input string what, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", what, act, exp);
        end
    endtask

    // Fill every FIFO with n random words and queue the expected beats.
    task automatic fill(input int n);
        logic [DW-1:0] beat;
        for (int pe = 0; pe < TOT; pe++) begin
            for (int i = 0; i < n; i++) fifo[pe].push_back(W'($urandom));
        end
        for (int k = P - 1; k >= 0; k--) begin
            for (int i = 0; i < n; i++) begin
                for (int r = 0; r < ROW; r++) begin
                    beat[r*2*W +: W]     = fifo[r*COL + 2*k][i];
                    beat[r*2*W + W +: W] = fifo[r*COL + 2*k + 1][i];
                end
                exp_q.push_back(beat);
            end
        end
    endtask

    task automatic clear_model();
        for (int pe = 0; pe < TOT; pe++) fifo[pe].delete();
        exp_q.delete();
    endtask

    function automatic int fifo_left();
        int s = 0;
        for (int pe = 0; pe < TOT; pe++) s += fifo[pe].size();
        return s;
    endfunction

    // Runs one drain. Cycle 0 is the start cycle; inputs are driven at the negedge and
    // outputs sampled 1 time unit later.
    task automatic run_drain(input int n, input int lo, input int hi, input bit rnd,
                             input int restart_at, output int done_cyc, output longint vmask,
                             output int beats, output int uflow_cyc, output int rd_bits,
                             output bit uflow_at_done, output int stalls);
        done_cyc = -1; vmask = 0; beats = 0; uflow_cyc = -1; rd_bits = 0;
        uflow_at_done = 1'b0; stalls = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            start = (t == 0) || (t == restart_at);
            n_entries = (t == 0) ? CW'(n) : CW'(7);
            oif.out_ready = rnd ? ($urandom_range(0, 9) < 7) : !(t >= lo && t <= hi);
            #1;
            if (t > 0 && done) begin
                done_cyc = t;
                uflow_at_done = underflow_err;
                break;
            end
            if (oif.out_valid && t < 64) vmask[t] = 1'b1;
            rd_bits += $countones(rd);
            if (t > 0 && underflow_err && uflow_cyc < 0) uflow_cyc = t;
            if (busy && oif.out_valid && !oif.out_ready) stalls++;
            if (oif.out_valid && oif.out_ready) begin
                beats++;
                if (exp_q.size() == 0) chk_eq("extra_beat", oif.out_data, '0);
                else chk_eq("beat_data", oif.out_data, exp_q.pop_front());
            end
        end
        start = 1'b0;
        oif.out_ready = 1'b1;
    endtask

    typedef struct {
        int      n;
        int      lo;
        int      hi;
        logic [TOT-1:0] fm;
        int      restart_at;
        int      exp_done;
        longint  exp_vmask;
        int      exp_beats;
        bit      exp_uflow;
        int      exp_uflow_cyc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int     done_cyc, beats, uflow_cyc, rd_bits, stalls, dcount;
        longint vmask;
        bit     ufd;

        vecs[0] = '{3, -1, -1, 8'h00, -1, 10, 64'h1DC, 6, 1'b0, -1};
        vecs[1] = '{3,  3,  5, 8'h00, -1, 13, 64'hEFC, 6, 1'b0, -1};
        vecs[2] = '{0, -1, -1, 8'h00, -1,  2, 64'h000, 0, 1'b0, -1};
        vecs[3] = '{3, -1, -1, 8'h02, -1, 10, 64'h1DC, 6, 1'b1,  5};
        vecs[4] = '{1, -1, -1, 8'h00, -1,  6, 64'h014, 2, 1'b0, -1};
        vecs[5] = '{4,  5,  5, 8'h00, -1, 13, 64'hF7C, 8, 1'b0, -1};
        vecs[6] = '{3, -1, -1, 8'h00,  4, 10, 64'h1DC, 6, 1'b0, -1};

        oif.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_eq("reset_busy", busy, 0);
        chk_eq("reset_done", done, 0);
        chk_eq("reset_uflow", underflow_err, 0);
        chk_eq("reset_valid", oif.out_valid, 0);
        chk_eq("reset_ctrl", {rd, sel, oten}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- table-driven directed drains ----------------
        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].n);
            fmask = vecs[v].fm;
            run_drain(vecs[v].n, vecs[v].lo, vecs[v].hi, 1'b0, vecs[v].restart_at,
                      done_cyc, vmask, beats, uflow_cyc, rd_bits, ufd, stalls);
            fmask = '0;
            chk_eq($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_done);
            chk_eq($sformatf("v%0d_valid_cycles", v), vmask, vecs[v].exp_vmask);
            chk_eq($sformatf("v%0d_beats", v), beats, vecs[v].exp_beats);
            chk_eq($sformatf("v%0d_read_bits", v), rd_bits, ROW * 2 * P * vecs[v].n);
            chk_eq($sformatf("v%0d_uflow_at_done", v), ufd, vecs[v].exp_uflow);
            chk_eq($sformatf("v%0d_uflow_first", v), uflow_cyc, vecs[v].exp_uflow_cyc);
            chk_eq($sformatf("v%0d_beats_left", v), exp_q.size(), 0);
            @(negedge clk);
            #1;
            chk_eq($sformatf("v%0d_done_pulse_len", v), {done, busy}, 0);
`ifdef PE_DRAIN_STALL_CNT_EN
            chk_eq($sformatf("v%0d_stall_cycles", v), stall_cycles, stalls);
`endif
            clear_model();
        end

        // ---------------- reset in cycle 5 of a drain ----------------
        fill(3);
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            start = (t == 0);
            n_entries = CW'(3);
            if (t == 5) rst_n = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        #1;
        chk_eq("rst_mid_busy", busy, 0);
        chk_eq("rst_mid_valid", oif.out_valid, 0);
        chk_eq("rst_mid_ctrl", {rd, sel, oten}, 0);
        chk_eq("rst_mid_done", done, 0);
        dcount = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            if (done) dcount++;
        end
        chk_eq("rst_mid_no_done", dcount, 0);
        clear_model();

        // ---------------- randomized drains under random backpressure ----------------
        for (int it = 0; it < 20; it++) begin
            int n;
            n = $urandom_range(1, 8);
            fill(n);
            run_drain(n, -1, -1, 1'b1, -1, done_cyc, vmask, beats, uflow_cyc, rd_bits, ufd,
                      stalls);
            chk_eq($sformatf("r%0d_done_seen", it), done_cyc >= 0, 1);
            chk_eq($sformatf("r%0d_beats", it), beats, P * n);
            chk_eq($sformatf("r%0d_read_bits", it), rd_bits, ROW * 2 * P * n);
            chk_eq($sformatf("r%0d_fifos_drained", it), fifo_left(), 0);
            chk_eq($sformatf("r%0d_uflow", it), ufd, 0);
`ifdef PE_DRAIN_STALL_CNT_EN
            @(negedge clk);
            #1;
            chk_eq($sformatf("r%0d_stall_cycles", it), stall_cycles, stalls);
`endif
            clear_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
